// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, functional-unit indices,
// the reserved "no producer" tag and the CDB output-stage state type.
package tomasulo_pkg;

   localparam int NREQ_DEF  = 3;   // ADD, MUL, LD
   localparam int TAGW_DEF  = 6;
   localparam int DATAW_DEF = 16;

   localparam int FU_ADD = 0;
   localparam int FU_MUL = 1;
   localparam int FU_LD  = 2;

   // Tag 0 means "value present, no producer" in register status, so it can
   // never be retired on the CDB.
   localparam int TAG_EMPTY = 0;

   typedef enum logic {
      CDB_EMPTY = 1'b0,
      CDB_FULL  = 1'b1
   } cdb_state_e;

   // Width of an index into an n-entry vector (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester found searching upward from
// last_grant_i+1 with wrap-around. Purely combinational so it can be reused
// by issue logic with its own pointer register.
module rr_arbiter
   import tomasulo_pkg::*;
#(
   parameter  int N    = NREQ_DEF,
   localparam int IDXW = idx_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] last_grant_i,
   output logic [N-1:0]    grant_o
);

   logic found;

   // Two passes: indices above the last grant first, then wrap to the bottom.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment, otherwise synthesis infers a latch.
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i > int'(last_grant_i))) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i <= int'(last_grant_i))) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one functional-unit result per cycle by
// round-robin, registers it for one-cycle-latency broadcast, holds it while
// consumers stall, and drops tag-0 results while flagging them.
module cdb_arbiter
   import tomasulo_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int TAGW  = TAGW_DEF,
   parameter int DATAW = DATAW_DEF
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*TAGW-1:0]  req_tag,
   input  logic [NREQ*DATAW-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  cdb_stall,
   output logic                  cdb_valid,
   output logic [TAGW-1:0]       cdb_tag,
   output logic [DATAW-1:0]      cdb_data,
   output logic                  bad_tag,
   output logic [15:0]           bcast_count
);

   localparam int              IDXW     = idx_width(NREQ);
   localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);  // FU 0 wins first

   cdb_state_e        state_q;
   logic [TAGW-1:0]   tag_q;
   logic [DATAW-1:0]  data_q;
   logic              bad_tag_q;
   logic [15:0]       count_q;
   logic [IDXW-1:0]   last_grant_q;
   logic [IDXW-1:0]   last_grant_d;

   logic [NREQ-1:0]   grant;
   logic [TAGW-1:0]   sel_tag;
   logic [DATAW-1:0]  sel_data;
   logic              xfer;
   logic              tag_zero;
   logic              load;
   logic              complete;

   rr_arbiter #(.N(NREQ)) u_rr (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // With no stall a full register always drains this edge, so stall alone
   // decides whether the output stage can take a new result.
   assign req_ready = (Resetn && !cdb_stall) ? grant : '0;
   assign xfer      = |req_ready;

   // Mux the granted FU's tag/data and encode its index for the pointer.
   always_comb begin
      sel_tag      = '0;
      sel_data     = '0;
      last_grant_d = last_grant_q;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_tag      = req_tag[i*TAGW +: TAGW];
            sel_data     = req_data[i*DATAW +: DATAW];
            last_grant_d = IDXW'(i);
         end
      end
   end

   assign tag_zero = (sel_tag == TAGW'(TAG_EMPTY));
   assign load     = xfer && !tag_zero;
   assign complete = (state_q == CDB_FULL) && !cdb_stall;

   // Output stage FSM: EMPTY/FULL with the broadcast tag/data registered.
   always_ff @(posedge Clock or negedge Resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!Resetn) begin
         state_q <= CDB_EMPTY;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            CDB_EMPTY: begin
               if (load) begin
                  state_q <= CDB_FULL;
                  tag_q   <= sel_tag;
                  data_q  <= sel_data;
               end
            end
            CDB_FULL: begin
               if (!cdb_stall) begin
                  if (load) begin
                     tag_q  <= sel_tag;
                     data_q <= sel_data;
                  end else begin
                     state_q <= CDB_EMPTY;
                     tag_q   <= '0;
                     data_q  <= '0;
                  end
               end
            end
         endcase
      end
   end

   // Arbitration pointer, sticky tag-0 flag and broadcast counter.
   always_ff @(posedge Clock or negedge Resetn) begin
      // NOTE: all of these are software-visible or steer arbitration, so each
      // gets an explicit reset value rather than relying on first-use writes.
      if (!Resetn) begin
         last_grant_q <= LAST_RST;
         bad_tag_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         if (xfer) begin
            last_grant_q <= last_grant_d;
         end
         if (xfer && tag_zero) begin
            bad_tag_q <= 1'b1;
         end
         if (complete) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

   assign cdb_valid   = (state_q == CDB_FULL);
   assign cdb_tag     = tag_q;
   assign cdb_data    = data_q;
   assign bad_tag     = bad_tag_q;
   assign bcast_count = count_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of functional-unit requesters (0=ADD, 1=MUL, 2=LD).
REQ-002 SHALL have parameter TAGW, default 6, reservation-station tag width.
REQ-003 SHALL have parameter DATAW, default 16, result data width.
REQ-004 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-FU result available.
REQ-007 SHALL have port req_tag  input  NREQ*TAGW  per-FU producing reservation-station tag.
REQ-008 SHALL have port req_data  input  NREQ*DATAW  per-FU result value.
REQ-009 SHALL have port req_ready  output  NREQ  per-FU accept; one-hot or zero.
REQ-010 SHALL have port cdb_stall  input  1  consumers cannot take a broadcast this cycle.
REQ-011 SHALL have port cdb_valid  output  1  broadcast present on the CDB.
REQ-012 SHALL have port cdb_tag  output  TAGW  tag being retired; register-status entries matching it become free.
REQ-013 SHALL have port cdb_data  output  DATAW  result being broadcast.
REQ-014 SHALL have port bad_tag  output  1  sticky flag: a request with tag 0 was received.
REQ-015 SHALL have port bcast_count  output  16  number of broadcasts completed.

Function
REQ-016 A transfer from FU i SHALL occur on a rising edge where req_valid[i] and req_ready[i] are both 1.
REQ-017 req_ready SHALL be combinational: all zero while cdb_stall=1 or while the output register is full and not being drained; otherwise one-hot to the round-robin winner among valid requesters.
REQ-018 Round-robin SHALL search from index (last_grant+1) mod NREQ upward with wrap-around; last_grant SHALL update only on a transfer.
REQ-019 Accepted tag/data SHALL appear on cdb_tag/cdb_data with cdb_valid=1 exactly one cycle after the transfer edge (latency 1).
REQ-020 The output register SHALL hold its content, with cdb_valid=1, on every cycle cdb_stall=1; a broadcast completes on an edge where cdb_valid=1 and cdb_stall=0.
REQ-021 When a broadcast completes and a new transfer occurs on the same edge, the output register SHALL load the new result without a bubble (one broadcast per cycle sustained).
REQ-022 When a broadcast completes with no new transfer, cdb_valid SHALL drop to 0 next cycle; cdb_tag/cdb_data SHALL be 0 whenever cdb_valid=0.
REQ-023 Output FSM SHALL have two states: EMPTY (cdb_valid=0) and FULL (cdb_valid=1); EMPTY->FULL on transfer; FULL->EMPTY on completion without transfer; otherwise hold.
REQ-024 A request with tag 0 (reserved "no producer") SHALL be accepted, SHALL NOT be broadcast, and SHALL set bad_tag until reset.
REQ-025 bcast_count SHALL increment by 1 per completed broadcast and wrap from 0xFFFF to 0x0000.
REQ-026 A requester dropping req_valid before being granted SHALL lose nothing and SHALL not move last_grant.

Reset
REQ-027 Resetn=0 SHALL asynchronously force: state EMPTY, cdb_valid=0, cdb_tag=0, cdb_data=0, bad_tag=0, bcast_count=0, last_grant=NREQ-1 (so FU 0 wins first).
REQ-028 req_ready SHALL be all zero while Resetn=0.
REQ-029 Reset asserted mid-broadcast SHALL discard the held result; no broadcast is issued after release until a new transfer.

Structure
REQ-030 TAGW, DATAW, NREQ defaults, FU index constants (FU_ADD=0, FU_MUL=1, FU_LD=2) and TAG_EMPTY=0 SHALL live in shared package tomasulo_pkg.
REQ-031 The round-robin pick SHALL be a sub-module rr_arbiter (inputs req vector, last_grant; output one-hot grant), reusable by issue logic.

Verification
REQ-032 Reset release, FU0 valid tag=5 data=0x1234, no stall -> req_ready=001 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=0x1234; bcast_count=1 after that edge.
REQ-033 All three FUs valid continuously with tags 1,2,3, no stall -> broadcasts in order 1,2,3,1,... one per cycle, no bubbles.
REQ-034 Broadcast tag=7 held, cdb_stall=1 for 4 cycles -> cdb_tag stays 7, req_ready=000 throughout; stall drops -> next broadcast follows without a bubble if a request is waiting.
REQ-035 FU1 valid tag=0 -> accepted, cdb_valid stays 0, bad_tag=1 and remains 1 across later normal traffic until Resetn=0.
REQ-036 Resetn pulsed low while cdb_valid=1 tag=9 -> all outputs 0 immediately; after release, first grant with FU0 and FU2 valid goes to FU0.
REQ-037 Preload bcast_count to 0xFFFF via 65535 broadcasts, one more -> bcast_count=0x0000.
